// File: rtl/cam_ctrl_pkg.sv
// Shared types and width helpers for the tag-CAM write-side controller.
package cam_ctrl_pkg;

    // Framing state of the write side: between messages or inside one.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } state_t;

    // Pointer width for a power-of-two ring of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must be able to hold the value depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/msg_desc_fifo.sv
// Small synchronous FIFO of message descriptors. The head entry is read from
// flopped storage, so it is stable for the whole cycle after a push or pop.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module msg_desc_fifo
    import cam_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             desc_full,
    output logic             desc_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign desc_full  = (count_q == FULL_CNT);
    assign desc_empty = (count_q == '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !desc_empty;
    assign do_push    = push_i && (!desc_full || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // State register; reset clears storage so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cam_msg_ctrl.sv
// Write-side controller for the FIX tag CAM. Treats the CAM as a ring,
// frames incoming words into messages and queues (start, end, length)
// descriptors; space comes back when the consumer pops a descriptor.
//
// Handshakes: a word moves when wr_en_i && wr_ready_o on a rising edge; a
// descriptor moves when msg_valid_o && msg_ready_i on a rising edge. Neither
// valid depends on its ready, and wr_ready_o is formed from flops only.
module cam_msg_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MSG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  start_message_i,
    input  logic                  end_message_i,
    output logic                  wr_ready_o,
    output logic                  cam_wr_o,
    output logic [ADDR_WIDTH-1:0] cam_wr_addr_o,
    output logic [DATA_WIDTH-1:0] cam_wr_data_o,
    output logic                  msg_valid_o,
    input  logic                  msg_ready_i,
    output logic [ADDR_WIDTH-1:0] msg_start_addr_o,
    output logic [ADDR_WIDTH-1:0] msg_end_addr_o,
    output logic [ADDR_WIDTH:0]   msg_len_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  err_o,
    output state_t                dbg_state_o
);

    localparam int CAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH + 1)'(CAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    // Width follows ADDR_WIDTH, so the descriptor lives here, not in the package.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] start_addr;
        logic [ADDR_WIDTH-1:0] end_addr;
        logic [ADDR_WIDTH:0]   len;
    } desc_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] msg_base_q, msg_base_d;
    logic [ADDR_WIDTH:0]   partial_q, partial_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  cam_wr_q, cam_wr_d;
    logic [ADDR_WIDTH-1:0] cam_wr_addr_q, cam_wr_addr_d;
    logic [DATA_WIDTH-1:0] cam_wr_data_q, cam_wr_data_d;
    logic                  err_q, err_d;

    logic                  accept, pop, push, rewind, write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    desc_t                 push_desc, head_desc;
    logic                  desc_full, desc_empty;

    msg_desc_fifo #(
        .WIDTH ($bits(desc_t)),
        .DEPTH (MSG_DEPTH)
    ) u_desc_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (push),
        .din_i      (push_desc),
        .pop_i      (pop),
        .head_o     (head_desc),
        .desc_full  (desc_full),
        .desc_empty (desc_empty)
    );

    assign wr_ready_o       = (level_q != LVL_FULL) && !desc_full;
    assign accept           = wr_en_i && wr_ready_o;
    assign msg_valid_o      = !desc_empty;
    assign pop              = msg_valid_o && msg_ready_i;
    assign msg_start_addr_o = head_desc.start_addr;
    assign msg_end_addr_o   = head_desc.end_addr;
    assign msg_len_o        = head_desc.len;
    assign level_o          = level_q;
    assign full_o           = (level_q == LVL_FULL);
    assign empty_o          = (level_q == '0);
    assign cam_wr_o         = cam_wr_q;
    assign cam_wr_addr_o    = cam_wr_addr_q;
    assign cam_wr_data_o    = cam_wr_data_q;
    assign err_o            = err_q;
    assign dbg_state_o      = state_q;

    // Framing FSM, CAM write port and occupancy accounting.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        msg_base_d    = msg_base_q;
        partial_d     = partial_q;
        cam_wr_d      = 1'b0;
        cam_wr_addr_d = cam_wr_addr_q;
        cam_wr_data_d = cam_wr_data_q;
        err_d         = 1'b0;
        push          = 1'b0;
        push_desc     = '0;
        rewind        = 1'b0;
        write_en      = 1'b0;
        write_addr    = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (start_message_i) begin
                        write_en   = 1'b1;
                        msg_base_d = wr_ptr_q;
                        if (end_message_i) begin
                            push      = 1'b1;
                            push_desc = '{start_addr: wr_ptr_q, end_addr: wr_ptr_q, len: LEN_ONE};
                        end else begin
                            partial_d = LEN_ONE;
                            state_d   = IN_MSG;
                        end
                    end else begin
                        // Stray word outside a message is dropped.
                        err_d = 1'b1;
                    end
                end
            end
            IN_MSG: begin
                if (accept) begin
                    write_en = 1'b1;
                    if (start_message_i) begin
                        // Abandon the partial message and restart at its base.
                        err_d      = 1'b1;
                        rewind     = 1'b1;
                        write_addr = msg_base_q;
                        if (end_message_i) begin
                            push      = 1'b1;
                            push_desc = '{start_addr: msg_base_q, end_addr: msg_base_q, len: LEN_ONE};
                            partial_d = LEN_ZERO;
                            state_d   = IDLE;
                        end else begin
                            partial_d = LEN_ONE;
                        end
                    end else if (end_message_i) begin
                        push      = 1'b1;
                        push_desc = '{start_addr: msg_base_q, end_addr: wr_ptr_q,
                                      len: partial_q + LEN_ONE};
                        partial_d = LEN_ZERO;
                        state_d   = IDLE;
                    end else begin
                        partial_d = partial_q + LEN_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (write_en) begin
            cam_wr_d      = 1'b1;
            cam_wr_addr_d = write_addr;
            cam_wr_data_d = data_i;
            wr_ptr_d      = write_addr + PTR_ONE;
        end

        // Partial words count toward level; a restart frees them, a pop frees
        // the committed words of the head message.
        level_d = level_q
                + (write_en ? LEN_ONE : LEN_ZERO)
                - (rewind ? partial_q : LEN_ZERO)
                - (pop ? head_desc.len : LEN_ZERO);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            msg_base_q    <= '0;
            partial_q     <= '0;
            level_q       <= '0;
            cam_wr_q      <= 1'b0;
            cam_wr_addr_q <= '0;
            cam_wr_data_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            msg_base_q    <= msg_base_d;
            partial_q     <= partial_d;
            level_q       <= level_d;
            cam_wr_q      <= cam_wr_d;
            cam_wr_addr_q <= cam_wr_addr_d;
            cam_wr_data_q <= cam_wr_data_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: doc/cam_msg_ctrl.md
# cam_msg_ctrl

Parametrised write-side controller for the FIX parser tag CAM. It tracks the CAM as a circular buffer and frames incoming words into messages. Each completed message is queued as a (start, end, length) descriptor for the downstream field extractor. CAM space is reclaimed when the consumer pops a descriptor, which replaces the single-shot start/end latch and sticky full flag of the previous generation.

## Interface
- DATA_WIDTH, 32, width of one CAM word
- ADDR_WIDTH, 5, CAM address width; CAM_DEPTH = 2**ADDR_WIDTH
- MSG_DEPTH, 4, descriptor queue depth, power of two ≥ 2
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- wr_en_i  input  1  word offered this cycle
- data_i  input  DATA_WIDTH  word payload
- start_message_i  input  1  offered word is first of a message
- end_message_i  input  1  offered word is last of a message (may coincide with start)
- wr_ready_o  output  1  controller can accept a word this cycle
- cam_wr_o  output  1  CAM write strobe
- cam_wr_addr_o  output  ADDR_WIDTH  CAM write index
- cam_wr_data_o  output  DATA_WIDTH  CAM write data
- msg_valid_o  output  1  descriptor at queue head is valid
- msg_ready_i  input  1  consumer pops the head descriptor
- msg_start_addr_o  output  ADDR_WIDTH  first CAM index of head message
- msg_end_addr_o  output  ADDR_WIDTH  last CAM index of head message
- msg_len_o  output  ADDR_WIDTH+1  word count of head message, 1..CAM_DEPTH
- level_o  output  ADDR_WIDTH+1  CAM entries in use (committed + partial)
- full_o  output  1  level_o == CAM_DEPTH
- empty_o  output  1  level_o == 0
- err_o  output  1  one-cycle pulse on framing violation

## Operation
- Accept: a word is accepted when wr_en_i && wr_ready_o. wr_ready_o = !full_o && !desc_full.
- States are IDLE and IN_MSG.
  - IDLE + accepted start and !end: write the word, latch msg_base = wr_ptr, set partial = 1, go to IN_MSG.
  - IDLE + accepted start and end: single-word message. Write it and push the descriptor (base, base, 1). Stay in IDLE.
  - IDLE + accepted word without start: the word is dropped, not written, and err_o pulses. wr_ptr and level_o are unchanged.
  - IN_MSG + accepted word without start: write it and increment partial. If end is set, push (msg_base, wr_ptr, partial+1) and go to IDLE.
  - IN_MSG + accepted start: the partial message is discarded and err_o pulses. wr_ptr rewinds to msg_base, level_o drops by partial, and the word is written at msg_base as the new first word. If end is also set, push (msg_base, msg_base, 1) and go to IDLE; otherwise stay in IN_MSG with partial = 1.
- wr_ptr increments modulo CAM_DEPTH on every written word, so it wraps from CAM_DEPTH-1 to 0.
- msg_len is counted, never computed from address difference, so a message filling the whole CAM reports CAM_DEPTH.
- Pop: msg_valid_o && msg_ready_i removes the head descriptor and subtracts its msg_len from committed level.
- A write and a pop in the same cycle are both applied, giving level_o + 1 - len.
- msg_ready_i while !msg_valid_o is ignored.
- wr_ready_o does not depend on msg_ready_i, so there is no combinational path from pop to accept.

## Timing
- Reset values: all outputs 0 except wr_ready_o = 1 and empty_o = 1. State = IDLE, wr_ptr = 0, queue empty.
- Reset may assert mid-message or mid-pop. It aborts everything with no err_o and returns all outputs to their reset values.
- cam_wr_o, cam_wr_addr_o, cam_wr_data_o are registered: they appear 1 cycle after acceptance.
- A descriptor is visible on msg_valid_o 1 cycle after its end word is accepted, the same cycle as that word's cam_wr_o.
- level_o, full_o, empty_o, wr_ready_o update 1 cycle after the accept or pop that changes them.
- err_o is registered and pulses 1 cycle after the offending word.

## Structure
- Shared package cam_ctrl_pkg holds:
  - state_t enum {IDLE, IN_MSG}
  - function clog2-based helpers for derived widths
- The descriptor is a local packed struct because its width depends on ADDR_WIDTH.
- One sub-module, msg_desc_fifo, holds the descriptors:
  - MSG_DEPTH-entry synchronous FIFO, registered head output
  - push/pop with simultaneous push-on-full-with-pop allowed
  - outputs desc_full and desc_empty

## Test plan
All scenarios use ADDR_WIDTH=3 (CAM_DEPTH=8) and MSG_DEPTH=2.
- Basic message: 3-word message (start on word 0, end on word 2) from reset → cam_wr_addr_o 0,1,2. Then msg_valid_o=1, start=0, end=2, len=3, level_o=3. After pop, level_o=0 and empty_o=1.
- Wrap: pop 6 single-word messages, then send a 4-word message → addresses 6,7,0,1, descriptor start=6, end=1, len=4.
- Full CAM: one 8-word message → full_o=1, wr_ready_o=0 while undrained, len=8, start=0, end=7. Popping it restores wr_ready_o=1 and level_o=0.
- Restart and stray word: start plus 2 words, then a new start → err_o pulses, new word written at addr 0, level_o=1. A separate non-start word in IDLE → err_o pulses and cam_wr_o stays 0.
- Queue full and simultaneous events: two messages queued with no pop → wr_ready_o=0. Then a write and pop in the same cycle → level_o updates by +1-len. Reset asserted mid-message → all outputs return to their reset values asynchronously.
